regfile_wr_arbiter: RTL and testbench

- Shares the single register-file write port between two producers:
  - the in-order pipeline writeback stage, which has no backpressure and always wins;
  - the long-latency unit (divider / load-miss path), which uses a valid/ready handshake.
- Buffers long-latency results in a small FIFO and drains them into idle write-port cycles.
- Keeps a pending-write scoreboard so decode can stall on registers with results still in flight.
- Sits between writeback/long-latency unit and the regfile write port; the scoreboard query is driven from decode.

---
 rtl/regfile_wr_arbiter_pkg.sv | 19 +
 rtl/regfile_wr_fifo.sv | 64 ++++++
 rtl/regfile_wr_arbiter.sv | 130 +++++++++++++
 tb/tb_regfile_wr_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared register-file types and constants
// for the write-port arbiter slice.
package regfile_wr_arbiter_pkg;

  localparam int RegNumLog2 = 5;
  localparam int RegNum = 1 << RegNumLog2;

  typedef logic [RegNumLog2-1:0] RegAddrBus;
  typedef logic [31:0] RegBus;

  localparam RegBus ZeroWord = 32'h0;

  localparam logic WriteEnable = 1'b1;
  localparam logic WriteDisable = 1'b0;

  localparam logic RstnEnable = 1'b0;
  localparam logic RstnDisable = 1'b1;

endpackage

// File: rtl/regfile_wr_fifo.sv
// Small FIFO of {addr, data} pairs holding
// long-latency results until the port is idle.
module regfile_wr_fifo
  import regfile_wr_arbiter_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [ADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0] head_data,
  output logic              full,
  output logic              empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0] count;
  logic do_push;
  logic do_pop;

  assign full = (count == (PW+1)'(DEPTH));
  assign empty = (count == '0);
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  assign head_addr = addr_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];

  // Storage written at the tail; contents need no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      addr_mem[wr_ptr] <= push_addr;
      data_mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally since depth is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstnEnable) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      unique case ({do_push, do_pop})
        2'b10: count <= count + 1'b1;
        2'b01: count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port arbiter: writeback wins,
// long-latency results drain into idle cycles.
module regfile_wr_arbiter
  import regfile_wr_arbiter_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = RegNumLog2,
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_waddr,
  input  logic [DATA_W-1:0] wb_wdata,
  input  logic              lu_valid,
  output logic              lu_ready,
  input  logic [ADDR_W-1:0] lu_waddr,
  input  logic [DATA_W-1:0] lu_wdata,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_waddr,
  input  logic [ADDR_W-1:0] chk_addr1,
  input  logic [ADDR_W-1:0] chk_addr2,
  input  logic [ADDR_W-1:0] chk_addr3,
  output logic              chk_busy1,
  output logic              chk_busy2,
  output logic              chk_busy3,
  output logic              stall_req,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata
);

  localparam int NREG = 1 << ADDR_W;
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic wb_active;
  logic push;
  logic pop;
  logic full;
  logic empty;
  logic alive_q;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic [NREG-1:0] sb_q;
  logic [NREG-1:0] sb_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic stall_q;
  logic stall_d;

  assign wb_active = wb_we & (wb_waddr != '0);
  assign lu_ready = alive_q & ~full;
  assign push = lu_valid & lu_ready & (lu_waddr != '0);
  assign pop = ~wb_active & ~empty;
  assign stall_req = stall_q;

  regfile_wr_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_addr (lu_waddr),
    .push_data (lu_wdata),
    .pop       (pop),
    .head_addr (head_addr),
    .head_data (head_data),
    .full      (full),
    .empty     (empty)
  );

  // Write port mux: writeback first, else FIFO head.
  always_comb begin
    we = WriteDisable;
    waddr = '0;
    wdata = '0;
    unique case (1'b1)
      wb_active: begin
        we = WriteEnable;
        waddr = wb_waddr;
        wdata = wb_wdata;
      end
      pop: begin
        we = WriteEnable;
        waddr = head_addr;
        wdata = head_data;
      end
      default: ;
    endcase
  end

  // Scoreboard next state: clear on drain, set on issue (set wins).
  always_comb begin
    sb_d = sb_q;
    if (pop) sb_d[head_addr] = 1'b0;
    if (iss_valid && (iss_waddr != '0)) sb_d[iss_waddr] = 1'b1;
  end

  assign chk_busy1 = sb_q[chk_addr1] & ~(pop & (head_addr == chk_addr1));
  assign chk_busy2 = sb_q[chk_addr2] & ~(pop & (head_addr == chk_addr2));
  assign chk_busy3 = sb_q[chk_addr3] & ~(pop & (head_addr == chk_addr3));

  // Starvation counter saturates; stall holds until a drain.
  always_comb begin
    cnt_d = cnt_q;
    if (empty || pop) cnt_d = '0;
    else if (cnt_q != CW'(STARVE_LIMIT)) cnt_d = cnt_q + 1'b1;
    stall_d = stall_q | (cnt_d == CW'(STARVE_LIMIT));
    if (pop) stall_d = 1'b0;
  end

  // State registers; ready stays low until the first edge after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstnEnable) begin
      alive_q <= 1'b0;
      sb_q <= '0;
      cnt_q <= '0;
      stall_q <= 1'b0;
    end else begin
      alive_q <= 1'b1;
      sb_q <= sb_d;
      cnt_q <= cnt_d;
      stall_q <= stall_d;
    end
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter with a
// queue of expected regfile writes.
module tb_regfile_wr_arbiter;

  logic clk = 1'b0;
  logic rst;
  logic wb_we;
  logic [4:0] wb_waddr;
  logic [31:0] wb_wdata;
  logic lu_valid;
  logic lu_ready;
  logic [4:0] lu_waddr;
  logic [31:0] lu_wdata;
  logic iss_valid;
  logic [4:0] iss_waddr;
  logic [4:0] chk_addr1;
  logic [4:0] chk_addr2;
  logic [4:0] chk_addr3;
  logic chk_busy1;
  logic chk_busy2;
  logic chk_busy3;
  logic stall_req;
  logic we;
  logic [4:0] waddr;
  logic [31:0] wdata;

  typedef struct packed {
    logic [4:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t exp_q[$];
  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  regfile_wr_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .wb_we     (wb_we),
    .wb_waddr  (wb_waddr),
    .wb_wdata  (wb_wdata),
    .lu_valid  (lu_valid),
    .lu_ready  (lu_ready),
    .lu_waddr  (lu_waddr),
    .lu_wdata  (lu_wdata),
    .iss_valid (iss_valid),
    .iss_waddr (iss_waddr),
    .chk_addr1 (chk_addr1),
    .chk_addr2 (chk_addr2),
    .chk_addr3 (chk_addr3),
    .chk_busy1 (chk_busy1),
    .chk_busy2 (chk_busy2),
    .chk_busy3 (chk_busy3),
    .stall_req (stall_req),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic expect_wr(input logic [4:0] ea, input logic [31:0] ed);
    exp_q.push_back(wr_t'{a: ea, d: ed});
  endtask

  // Monitor: every regfile write must match the queue head.
  always @(negedge clk) begin : mon
    wr_t e;
    if (rst === 1'b1 && we === 1'b1) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got addr %0d data %0h, required none",
                 waddr, wdata);
      end else begin
        e = exp_q.pop_front();
        if (waddr !== e.a || wdata !== e.d) begin
          n_fail++;
          $display("FAIL write: got addr %0d data %0h required addr %0d data %0h",
                   waddr, wdata, e.a, e.d);
        end
      end
    end
  end

  initial begin
    rst = 1'b0;
    wb_we = 0; wb_waddr = 0; wb_wdata = 0;
    lu_valid = 0; lu_waddr = 0; lu_wdata = 0;
    iss_valid = 0; iss_waddr = 0;
    chk_addr1 = 0; chk_addr2 = 0; chk_addr3 = 0;

    #12;
    chk("rst_lu_ready", lu_ready, 0);
    chk("rst_we", we, 0);
    chk("rst_stall", stall_req, 0);
    tick(); tick();
    rst = 1'b1;
    tick(); sample();
    chk("idle_lu_ready", lu_ready, 1);
    chk("idle_we", we, 0);
    chk("idle_busy", {chk_busy1, chk_busy2, chk_busy3}, 0);
    chk("idle_stall", stall_req, 0);

    // Issue to 5, result returns three cycles later.
    tick();
    iss_valid = 1; iss_waddr = 5; chk_addr1 = 5; chk_addr3 = 5;
    sample();
    chk("busy_issue_cycle", chk_busy1, 0);
    tick();
    iss_valid = 0;
    sample();
    chk("busy1_after_issue", chk_busy1, 1);
    chk("busy3_after_issue", chk_busy3, 1);
    tick(); sample();
    tick();
    lu_valid = 1; lu_waddr = 5; lu_wdata = 32'hDEADBEEF;
    expect_wr(5, 32'hDEADBEEF);
    sample();
    chk("no_same_cycle_drain", we, 0);
    chk("busy_before_drain", chk_busy1, 1);
    tick();
    lu_valid = 0;
    sample();
    chk("drain_we", we, 1);
    chk("busy_bypass", chk_busy1, 0);
    tick(); sample();
    chk("busy_cleared", chk_busy1, 0);
    chk("we_after_drain", we, 0);

    // Collision: writeback hogs the port, starvation stall.
    for (int k = 0; k < 6; k++) begin
      tick();
      wb_we = 1; wb_waddr = 3; wb_wdata = 32'h300 + k;
      lu_valid = (k == 0); lu_waddr = 7; lu_wdata = 32'h77;
      expect_wr(3, 32'h300 + k);
      sample();
      chk("starve_stall", stall_req, (k >= 5));
    end
    tick();
    wb_we = 0; lu_valid = 0;
    expect_wr(7, 32'h77);
    sample();
    chk("stall_held_on_pop", stall_req, 1);
    chk("held_entry_we", we, 1);
    tick(); sample();
    chk("stall_released", stall_req, 0);
    chk("we_after_release", we, 0);

    // Fill FIFO while writeback busy; third result waits.
    tick();
    wb_we = 1; wb_waddr = 4; wb_wdata = 32'h40;
    lu_valid = 1; lu_waddr = 8; lu_wdata = 32'h88;
    expect_wr(4, 32'h40);
    sample();
    chk("fill_ready0", lu_ready, 1);
    tick();
    wb_wdata = 32'h41; lu_waddr = 9; lu_wdata = 32'h99;
    expect_wr(4, 32'h41);
    sample();
    chk("fill_ready1", lu_ready, 1);
    tick();
    wb_wdata = 32'h42; lu_waddr = 10; lu_wdata = 32'hAA;
    expect_wr(4, 32'h42);
    sample();
    chk("full_not_ready", lu_ready, 0);
    tick();
    wb_we = 0;
    expect_wr(8, 32'h88);
    sample();
    chk("pop_no_ready_raise", lu_ready, 0);
    tick();
    expect_wr(9, 32'h99);
    sample();
    chk("ready_after_pop", lu_ready, 1);
    tick();
    lu_valid = 0;
    expect_wr(10, 32'hAA);
    sample();
    chk("fill_no_stall", stall_req, 0);
    tick(); sample();
    chk("fill_drained", we, 0);

    // Address-0 writeback and address-0 long-latency result.
    tick();
    lu_valid = 1; lu_waddr = 12; lu_wdata = 32'hC0C0;
    sample();
    tick();
    lu_waddr = 0; lu_wdata = 32'hBAD;
    wb_we = 1; wb_waddr = 0; wb_wdata = 32'hBAD0;
    expect_wr(12, 32'hC0C0);
    sample();
    chk("wb_zero_fifo_wins", we, 1);
    chk("zero_lu_ready", lu_ready, 1);
    tick();
    lu_valid = 0; wb_we = 0;
    sample();
    chk("zero_lu_dropped", we, 0);
    tick(); sample();
    chk("zero_lu_dropped2", we, 0);

    // Reset with a full FIFO and busy scoreboard bits.
    tick();
    iss_valid = 1; iss_waddr = 20;
    sample();
    tick();
    iss_waddr = 21;
    sample();
    tick();
    iss_valid = 0;
    wb_we = 1; wb_waddr = 2; wb_wdata = 32'h200;
    lu_valid = 1; lu_waddr = 20; lu_wdata = 32'h2020;
    expect_wr(2, 32'h200);
    sample();
    tick();
    wb_wdata = 32'h201; lu_waddr = 21; lu_wdata = 32'h2121;
    expect_wr(2, 32'h201);
    sample();
    tick();
    wb_wdata = 32'h202; lu_valid = 0;
    chk_addr1 = 20; chk_addr2 = 21;
    expect_wr(2, 32'h202);
    sample();
    chk("pre_rst_full", lu_ready, 0);
    chk("pre_rst_busy", {chk_busy1, chk_busy2}, 2'b11);
    #2;
    wb_we = 0;
    rst = 1'b0;
    #1;
    chk("async_rst_we", we, 0);
    chk("async_rst_ready", lu_ready, 0);
    chk("async_rst_busy", {chk_busy1, chk_busy2}, 0);
    chk("async_rst_stall", stall_req, 0);
    tick(); tick();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(); sample();
      chk("post_rst_we", we, 0);
      chk("post_rst_busy", {chk_busy1, chk_busy2}, 0);
    end
    chk("post_rst_ready", lu_ready, 1);
    chk("all_writes_seen", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
